tapped_shift_line: RTL and testbench
====================================

Name: tapped_shift_line

Overview:
- Parametrised successor to the team's tapped FIFO: a DEPTH-entry shift line of WIDTH-bit words that advances only on qualified input.
- Exposes a subsampled set of taps (every TAP_STRIDE entries) with per-tap valid bits, a fill count and an evicted-word output.
- Supports flush between image lines.
- Feeds the census/window stages, where the line must stall with the pixel stream and restart cleanly at line boundaries.

Parameters:
- WIDTH, 32, bits per word.
- DEPTH, 10, number of entries; must be at least 1.
- TAP_STRIDE, 1, tap spacing in entries. DEPTH must be a multiple of TAP_STRIDE.
- NUM_TAPS (localparam), DEPTH/TAP_STRIDE.
- CW (localparam), $clog2(DEPTH+1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  qualifies inp; the line shifts only when high.
- inp  in  WIDTH  input word.
- flush  in  1  synchronous clear of line contents and valid state.
- taps  out  WIDTH*NUM_TAPS  tap k at bits [k*WIDTH +: WIDTH].
- tap_valid  out  NUM_TAPS  bit k is high when tap k holds an accepted word.
- outp  out  WIDTH  word evicted from the oldest entry.
- out_valid  out  1  one-cycle qualifier for outp.
- full  out  1  high when all DEPTH entries hold accepted words.
- fill_count  out  CW  number of valid entries, 0..DEPTH.

Behaviour:
- Storage: entries e[0..DEPTH-1], each with a valid bit v[i]. e[0] is the newest entry.
- Tap mapping: tap k = e[k*TAP_STRIDE + TAP_STRIDE-1] and tap_valid[k] = v[same index]. The last tap is therefore always e[DEPTH-1].
- Reset (rst=1 at a clock edge) forces all of the following to 0: every e and v, taps, tap_valid, outp, out_valid, full, fill_count. Reset overrides flush and in_valid.
- Priority at each edge: rst, then flush, then in_valid.
- Flush (rst=0, flush=1):
  - all e cleared to 0, all v to 0, fill_count to 0, out_valid to 0;
  - outp holds its last value;
  - an in_valid word in the same cycle is dropped.
- Shift (rst=0, flush=0, in_valid=1):
  - e[0]<=inp and v[0]<=1;
  - e[i]<=e[i-1] and v[i]<=v[i-1] for i=1..DEPTH-1;
  - outp<=old e[DEPTH-1] and out_valid<=old v[DEPTH-1];
  - fill_count<=min(fill_count+1, DEPTH), saturating.
- Stall (rst=0, flush=0, in_valid=0):
  - all e, v and fill_count hold;
  - out_valid<=0 and outp holds.
- Latency: a word accepted at edge n appears on tap 0 after edge n (when TAP_STRIDE=1). It reaches e[DEPTH-1] after DEPTH accepted shifts and appears on outp with out_valid at the (DEPTH+1)th accepted shift.
- full is registered and equals (fill_count==DEPTH). full is high only once the line is full, and it stays high under further shifts (saturation) until flush or rst.
- Valid bits form a contiguous run from index 0. fill_count equals the number of set v bits at all times.
- All outputs are registered or direct register taps; there is no combinational input-to-output path.
- DEPTH=1: taps=e[0]. outp and out_valid reflect the evicted e[0] on each subsequent shift.
- No backpressure: every in_valid word is accepted. Evicted words appear on outp for exactly one cycle.

Test Plan:
- WIDTH=8, DEPTH=4, STRIDE=1; rst for 2 cycles, then in_valid with 0x11,0x22,0x33,0x44 on consecutive cycles:
  - after edge 4: taps={0x11,0x22,0x33,0x44} (tap3..tap0), tap_valid=4'b1111, full=1, fill_count=4, out_valid never yet asserted;
  - then 0x55: outp=0x11 and out_valid=1 for one cycle, fill_count stays 4.
- Same config, accept 0x11, deassert in_valid for 3 cycles, then accept 0x22:
  - taps hold during the stall, out_valid=0 throughout;
  - after 0x22: tap0=0x22, tap1=0x11, tap_valid=4'b0011, fill_count=2.
- Full line, then flush=1 and in_valid=1 with 0x99 in the same cycle:
  - next cycle: all taps 0, tap_valid=0, fill_count=0, full=0, out_valid=0, 0x99 absent;
  - next accepted 0xAA lands at tap0 with fill_count=1.
- DEPTH=6, STRIDE=2 (NUM_TAPS=3); accept 1..6:
  - taps (tap2..tap0)={1,3,5}, i.e. tap0=e[1]=5, tap1=e[3]=3, tap2=e[5]=1, tap_valid=3'b111;
  - after only 3 accepts: tap_valid=3'b001.
- Mid-fill rst with in_valid=1 and flush=1 in the same cycle:
  - all outputs 0 next cycle, fill_count=0;
  - refill proceeds exactly as from power-on.
- DEPTH=1: accept 0x7 then 0x8 → after the second edge, tap0=0x8, outp=0x7, out_valid=1, full=1.

Source files
------------

// File: rtl/tapped_shift_line.sv
// Tapped shift line: DEPTH-entry word line that advances on qualified input.
// Strided taps with valid bits, fill count, full flag and an evicted-word port.

module tsl_entry #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift,
    input  logic [WIDTH-1:0] prev_data,
    input  logic             prev_vld,
    output logic [WIDTH-1:0] data,
    output logic             vld
);
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            data <= '0;
            vld  <= 1'b0;
        end else if (shift) begin
            data <= prev_data;
            vld  <= prev_vld;
        end
    end
endmodule

module tapped_shift_line #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 10,
    parameter int TAP_STRIDE = 1,
    localparam int NUM_TAPS  = DEPTH / TAP_STRIDE,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          inp,
    input  logic                      flush,
    output logic [WIDTH*NUM_TAPS-1:0] taps,
    output logic [NUM_TAPS-1:0]       tap_valid,
    output logic [WIDTH-1:0]          outp,
    output logic                      out_valid,
    output logic                      full,
    output logic [CW-1:0]             fill_count
);
    // Slot 0 is the incoming word; slot i+1 is entry e[i].
    logic [DEPTH:0][WIDTH-1:0] data_pipe;
    logic [DEPTH:0]            vld_pipe;

    assign data_pipe[0] = inp;
    assign vld_pipe[0]  = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            tsl_entry #(.WIDTH(WIDTH)) u_entry (
                .clk       (clk),
                .rst       (rst),
                .clear     (flush),
                .shift     (in_valid),
                .prev_data (data_pipe[gi]),
                .prev_vld  (vld_pipe[gi]),
                .data      (data_pipe[gi+1]),
                .vld       (vld_pipe[gi+1])
            );
        end

        for (gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
            assign taps[gi*WIDTH +: WIDTH] = data_pipe[gi*TAP_STRIDE + TAP_STRIDE];
            assign tap_valid[gi]           = vld_pipe[gi*TAP_STRIDE + TAP_STRIDE];
        end
    endgenerate

    // Once full, the count saturates and full stays set until flush/rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            outp       <= '0;
            out_valid  <= 1'b0;
            fill_count <= '0;
            full       <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            fill_count <= '0;
            full       <= 1'b0;
        end else if (in_valid) begin
            outp      <= data_pipe[DEPTH];
            out_valid <= vld_pipe[DEPTH];
            if (!full) begin
                fill_count <= fill_count + 1'b1;
                full       <= (fill_count == CW'(DEPTH - 1));
            end
        end else begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_tapped_shift_line.sv
// Bench: three configurations (4x1, 6x2, 1x1) share one stimulus stream and
// are checked against a history-queue model of accepted words.

module tb_tapped_shift_line;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] inp = '0;
    logic       flush = 1'b0;

    always #5 clk = ~clk;

    logic [31:0] taps_a;  logic [3:0] tv_a; logic [7:0] outp_a; logic ov_a, full_a; logic [2:0] fill_a;
    logic [23:0] taps_b;  logic [2:0] tv_b; logic [7:0] outp_b; logic ov_b, full_b; logic [2:0] fill_b;
    logic [7:0]  taps_c;  logic [0:0] tv_c; logic [7:0] outp_c; logic ov_c, full_c; logic [0:0] fill_c;

    tapped_shift_line #(.WIDTH(8), .DEPTH(4), .TAP_STRIDE(1)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .inp(inp), .flush(flush),
        .taps(taps_a), .tap_valid(tv_a), .outp(outp_a), .out_valid(ov_a),
        .full(full_a), .fill_count(fill_a));
    tapped_shift_line #(.WIDTH(8), .DEPTH(6), .TAP_STRIDE(2)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .inp(inp), .flush(flush),
        .taps(taps_b), .tap_valid(tv_b), .outp(outp_b), .out_valid(ov_b),
        .full(full_b), .fill_count(fill_b));
    tapped_shift_line #(.WIDTH(8), .DEPTH(1), .TAP_STRIDE(1)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .inp(inp), .flush(flush),
        .taps(taps_c), .tap_valid(tv_c), .outp(outp_c), .out_valid(ov_c),
        .full(full_c), .fill_count(fill_c));

    // Observed state per instance: {taps, tap_valid, fill, full, outp, out_valid}
    logic [49:0] act [3];
    assign act[0] = {taps_a, tv_a, 1'b0, fill_a, full_a, outp_a, ov_a};
    assign act[1] = {8'h00, taps_b, 1'b0, tv_b, 1'b0, fill_b, full_b, outp_b, ov_b};
    assign act[2] = {24'h0, taps_c, 3'b000, tv_c, 3'b000, fill_c, full_c, outp_c, ov_c};

    int dep [3] = '{4, 6, 1};
    int str [3] = '{1, 2, 1};

    // Model: accepted words since last clear, newest first.
    logic [7:0] hist [$];
    logic [7:0] m_outp [3];
    logic       m_ov   [3];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [49:0] exp_state(int d);
        logic [31:0] t  = '0;
        logic [3:0]  tv = '0;
        int nt = dep[d] / str[d];
        int sz = hist.size();
        int f  = (sz < dep[d]) ? sz : dep[d];
        for (int k = 0; k < nt; k++) begin
            int idx = k * str[d] + str[d] - 1;
            if (idx < sz) begin
                t[k*8 +: 8] = hist[idx];
                tv[k] = 1'b1;
            end
        end
        return {t, tv, 4'(f), 1'(f == dep[d]), m_outp[d], m_ov[d]};
    endfunction

    task automatic drive(input logic r, input logic f, input logic iv, input logic [7:0] d);
        rst = r; flush = f; in_valid = iv; inp = d;
        @(posedge clk);
        if (r) begin
            hist.delete();
            for (int i = 0; i < 3; i++) begin m_outp[i] = '0; m_ov[i] = 1'b0; end
        end else if (f) begin
            hist.delete();
            for (int i = 0; i < 3; i++) m_ov[i] = 1'b0;
        end else if (iv) begin
            for (int i = 0; i < 3; i++) begin
                if (hist.size() >= dep[i]) begin
                    m_outp[i] = hist[dep[i]-1];
                    m_ov[i]   = 1'b1;
                end else begin
                    m_outp[i] = '0;
                    m_ov[i]   = 1'b0;
                end
            end
            hist.push_front(d);
            if (hist.size() > 7) void'(hist.pop_back());
        end else begin
            for (int i = 0; i < 3; i++) m_ov[i] = 1'b0;
        end
        #1;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_reset();
        drive(1, 0, 1, 8'h5A);
        drive(1, 1, 1, 8'hA5);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (act[i] !== 50'h0) begin
                n_bad++;
                $display("FAIL reset dut%0d: got %h want 0", i, act[i]);
            end
        end
    endtask

    task automatic test_fill_evict();
        logic [7:0] w [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic seen_ov = 1'b0;
        drive(0, 1, 0, 0);
        for (int j = 0; j < 4; j++) begin
            drive(0, 0, 1, w[j]);
            seen_ov |= ov_a;
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (act[i] !== exp_state(i)) begin
                    n_bad++;
                    $display("FAIL fill dut%0d step%0d: got %h want %h", i, j, act[i], exp_state(i));
                end
            end
        end
        n_cmp++;
        if ({taps_a, tv_a, full_a, fill_a, seen_ov} !== {32'h11223344, 4'hF, 1'b1, 3'd4, 1'b0}) begin
            n_bad++;
            $display("FAIL fill_full: got taps=%h tv=%b full=%b fill=%0d ov_seen=%b want 11223344 1111 1 4 0",
                     taps_a, tv_a, full_a, fill_a, seen_ov);
        end
        drive(0, 0, 1, 8'h55);
        n_cmp++;
        if ({outp_a, ov_a, fill_a, full_a} !== {8'h11, 1'b1, 3'd4, 1'b1}) begin
            n_bad++;
            $display("FAIL evict: got outp=%h ov=%b fill=%0d full=%b want 11 1 4 1", outp_a, ov_a, fill_a, full_a);
        end
        drive(0, 0, 0, 8'hEE);
        n_cmp++;
        if ({ov_a, outp_a} !== {1'b0, 8'h11}) begin
            n_bad++;
            $display("FAIL evict_pulse: got ov=%b outp=%h want 0 11", ov_a, outp_a);
        end
    endtask

    task automatic test_stall();
        drive(0, 1, 0, 0);
        drive(0, 0, 1, 8'h11);
        for (int j = 0; j < 3; j++) begin
            drive(0, 0, 0, 8'($urandom));
            n_cmp++;
            if ({taps_a, tv_a, fill_a, ov_a} !== {32'h00000011, 4'b0001, 3'd1, 1'b0}) begin
                n_bad++;
                $display("FAIL stall%0d: got taps=%h tv=%b fill=%0d ov=%b", j, taps_a, tv_a, fill_a, ov_a);
            end
        end
        drive(0, 0, 1, 8'h22);
        n_cmp++;
        if ({taps_a[15:0], tv_a, fill_a} !== {16'h1122, 4'b0011, 3'd2}) begin
            n_bad++;
            $display("FAIL stall_resume: got taps=%h tv=%b fill=%0d want 1122 0011 2", taps_a[15:0], tv_a, fill_a);
        end
    endtask

    task automatic test_flush();
        for (int j = 0; j < 4; j++) drive(0, 0, 1, 8'(8'h31 + j));
        drive(0, 1, 1, 8'h99);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (act[i] !== exp_state(i)) begin
                n_bad++;
                $display("FAIL flush dut%0d: got %h want %h", i, act[i], exp_state(i));
            end
        end
        n_cmp++;
        if ({taps_a, tv_a, fill_a, full_a, ov_a} !== 41'h0) begin
            n_bad++;
            $display("FAIL flush_clear: got taps=%h tv=%b fill=%0d full=%b ov=%b want all 0",
                     taps_a, tv_a, fill_a, full_a, ov_a);
        end
        drive(0, 0, 1, 8'hAA);
        n_cmp++;
        if ({taps_a, fill_a} !== {32'h000000AA, 3'd1}) begin
            n_bad++;
            $display("FAIL flush_refill: got taps=%h fill=%0d want 000000aa 1", taps_a, fill_a);
        end
    endtask

    task automatic test_stride();
        drive(0, 1, 0, 0);
        for (int j = 1; j <= 6; j++) begin
            drive(0, 0, 1, 8'(j));
            if (j == 3) begin
                n_cmp++;
                if (tv_b !== 3'b001) begin
                    n_bad++;
                    $display("FAIL stride_partial: got tv=%b want 001", tv_b);
                end
            end
        end
        n_cmp++;
        if ({taps_b, tv_b, full_b} !== {24'h010305, 3'b111, 1'b1}) begin
            n_bad++;
            $display("FAIL stride_taps: got taps=%h tv=%b full=%b want 010305 111 1", taps_b, tv_b, full_b);
        end
    endtask

    task automatic test_mid_reset();
        drive(0, 1, 0, 0);
        drive(0, 0, 1, 8'h61);
        drive(0, 0, 1, 8'h62);
        drive(1, 1, 1, 8'h63);
        n_cmp++;
        if ({act[0], act[1], act[2]} !== 150'h0) begin
            n_bad++;
            $display("FAIL mid_reset: got %h %h %h want all 0", act[0], act[1], act[2]);
        end
        for (int j = 0; j < 5; j++) begin
            drive(0, 0, 1, 8'(8'h70 + j));
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (act[i] !== exp_state(i)) begin
                    n_bad++;
                    $display("FAIL refill dut%0d step%0d: got %h want %h", i, j, act[i], exp_state(i));
                end
            end
        end
    endtask

    task automatic test_depth1();
        drive(0, 1, 0, 0);
        drive(0, 0, 1, 8'h07);
        drive(0, 0, 1, 8'h08);
        n_cmp++;
        if ({taps_c, outp_c, ov_c, full_c, fill_c} !== {8'h08, 8'h07, 1'b1, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL depth1: got tap=%h outp=%h ov=%b full=%b fill=%0d want 08 07 1 1 1",
                     taps_c, outp_c, ov_c, full_c, fill_c);
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 400; j++) begin
            logic r  = ($urandom_range(0, 49) == 0);
            logic f  = ($urandom_range(0, 19) == 0);
            logic iv = ($urandom_range(0, 9) < 6);
            drive(r, f, iv, 8'($urandom));
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (act[i] !== exp_state(i)) begin
                    n_bad++;
                    $display("FAIL random dut%0d cyc%0d: got %h want %h", i, j, act[i], exp_state(i));
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin m_outp[i] = '0; m_ov[i] = 1'b0; end
        test_reset();
        test_fill_evict();
        test_stall();
        test_flush();
        test_stride();
        test_mid_reset();
        test_depth1();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
